// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Time-slots a single-port video SRAM between the CRTC character
//            and attribute fetch and ISA CPU accesses.
// Options  : VRAM_BLANK_CPU_EN - give ph0 to the CPU while display is blanked.
// Revision : 1.0
// ============================================================================
module vram_arbiter #(
  parameter int CHAR_CLKS = 8,
  parameter int AW        = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          divclk,
  input  logic          display_enable,
  input  logic [13:0]   mem_addr,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_busy,
  output logic          cpu_done,
  output logic [7:0]    cpu_rdata,
  output logic [AW-1:0] ram_a,
  input  logic [7:0]    ram_d_in,
  output logic [7:0]    ram_d_out,
  output logic          ram_d_oe,
  output logic          ram_oe_l,
  output logic          ram_we_l,
  output logic [7:0]    vid_char,
  output logic [7:0]    vid_attr,
  output logic          vid_strobe
);

  localparam logic [3:0] C_PH_LAST = 4'(CHAR_CLKS - 1);

  logic [3:0]    r_ph;
  logic          r_pending;
  logic          r_we;
  logic          r_hold;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_wdata;
  logic [7:0]    r_char_tmp;
  logic          w_vid_on;
  logic          w_vid0;
  logic          w_vid1;
  logic          w_cpu_slot;
  logic          w_cpu_end;

`ifdef VRAM_BLANK_CPU_EN
  logic r_vid_on;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vid_on <= 1'b1;
    end else if (divclk) begin
      r_vid_on <= display_enable;
    end
  end

  assign w_vid_on = r_vid_on;
`else
  logic w_unused_de;

  assign w_unused_de = display_enable;
  assign w_vid_on    = 1'b1;
`endif

  assign w_vid0     = (r_ph == 4'd0) && w_vid_on;
  assign w_vid1     = (r_ph == 4'd1) && w_vid_on;
  assign w_cpu_slot = r_pending && ((r_ph == 4'd2) || ((r_ph == 4'd0) && !w_vid_on));
  // An early divclk aborts the slot: the access stays pending for the next grant.
  assign w_cpu_end  = w_cpu_slot && !divclk;
  assign cpu_busy   = cpu_req | r_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ph       <= C_PH_LAST;
      r_pending  <= 1'b0;
      r_we       <= 1'b0;
      r_hold     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_char_tmp <= '0;
      cpu_done   <= 1'b0;
      cpu_rdata  <= '0;
      vid_char   <= '0;
      vid_attr   <= '0;
      vid_strobe <= 1'b0;
    end else begin
      if (divclk) begin
        r_ph <= 4'd0;
      end else if (r_ph != C_PH_LAST) begin
        r_ph <= r_ph + 4'd1;
      end

      cpu_done   <= w_cpu_end;
      r_hold     <= w_cpu_end && r_we;
      vid_strobe <= w_vid1 && !divclk;

      if (w_vid0 && !divclk) begin
        r_char_tmp <= ram_d_in;
      end
      if (w_vid1 && !divclk) begin
        vid_char <= r_char_tmp;
        vid_attr <= ram_d_in;
      end
      if (w_cpu_end && !r_we) begin
        cpu_rdata <= ram_d_in;
      end

      if (w_cpu_end) begin
        r_pending <= 1'b0;
      end else if (cpu_req && !r_pending) begin
        r_pending <= 1'b1;
        r_we      <= cpu_we;
        r_addr    <= cpu_addr;
        r_wdata   <= cpu_wdata;
      end
    end
  end

  // Write hold keeps address and data stable one cycle past the WE rising edge.
  always_comb begin
    ram_a     = '0;
    ram_d_out = '0;
    ram_d_oe  = 1'b0;
    ram_oe_l  = 1'b1;
    ram_we_l  = 1'b1;
    if (r_hold) begin
      ram_a     = r_addr;
      ram_d_out = r_wdata;
      ram_d_oe  = 1'b1;
    end else if (w_cpu_slot) begin
      ram_a = r_addr;
      if (r_we) begin
        ram_d_out = r_wdata;
        ram_d_oe  = 1'b1;
        ram_we_l  = 1'b0;
      end else begin
        ram_oe_l = 1'b0;
      end
    end else if (w_vid0) begin
      ram_a    = AW'({mem_addr, 1'b0});
      ram_oe_l = 1'b0;
    end else if (w_vid1) begin
      ram_a    = AW'({mem_addr, 1'b1});
      ram_oe_l = 1'b0;
    end
  end

endmodule
`default_nettype wire
